fft_mag_writer: RTL and testbench
=================================

FFT_MAG_WRITER -- requirements
Module: fft_mag_writer

Interface
REQ-001 SHALL have parameter BINS, default 256, number of spectrum bins written (xk_index 0..BINS-1); legal 2..512.
REQ-002 SHALL have parameter DECAY, default 2, per-frame fall of each displayed bar in magnitude units (0 = no decay).
REQ-003 SHALL have port cclk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset; clock is cclk.
REQ-005 SHALL have port dv  in  1  FFT output data valid, one bin per cycle when high.
REQ-006 SHALL have port xk_index  in  9  FFT output bin index.
REQ-007 SHALL have port xk_re  in  8  signed two's-complement real part.
REQ-008 SHALL have port xk_im  in  8  signed two's-complement imaginary part.
REQ-009 SHALL have port clear  in  1  request to zero all bars (level, sampled in IDLE only).
REQ-010 SHALL have port wr_en  out  1  display-RAM write strobe.
REQ-011 SHALL have port wr_addr  out  9  display-RAM address.
REQ-012 SHALL have port wr_data  out  8  display-RAM data, bar height 0..255.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse after the last bin of a frame is written.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port overrun  out  1  sticky: a new frame started before the previous one completed; cleared only by reset.

Function
REQ-016 SHALL implement states CLEAR, IDLE, COLLECT, FLUSH, DONE.
REQ-017 CLEAR: write 0 to internal peak memory and to display (wr_en=1, wr_data=0) at addresses 0..BINS-1, one per cycle, then go to IDLE; dv ignored.
REQ-018 IDLE: clear=1 -> CLEAR; else dv=1 with xk_index=0 -> COLLECT and that sample is accepted; dv with any other index ignored.
REQ-019 COLLECT: every dv=1 with xk_index<BINS accepted into the pipeline; xk_index>=BINS dropped; dv gaps of any length allowed.
REQ-020 COLLECT -> FLUSH on the cycle index BINS-1 is accepted; FLUSH waits until the pipeline is empty, then DONE; DONE asserts frame_done for exactly one cycle, then IDLE.
REQ-021 In COLLECT, dv=1 with xk_index=0 (new frame before BINS-1 seen): set overrun, restart frame with this sample accepted; samples already in the pipeline still complete.
REQ-022 Pipeline: 3 cycles fixed; sample accepted at cycle N -> wr_en=1 with wr_addr=xk_index at cycle N+3; fully pipelined, one sample per cycle.
REQ-023 Stage 1: register re, im, index; read peak memory at index.
REQ-024 Stage 2: p = re*re + im*im, unsigned 16 bits, exact (max 32768 at re=im=-128).
REQ-025 Stage 3: m = p>>7, saturated to 255; old' = old - DECAY saturated at 0; bar = max(m, old'); write bar to peak memory and wr_data.
REQ-026 Back-to-back accepts of the same index SHALL forward the in-flight stage-3 result instead of the stale memory value (read-after-write bypass).
REQ-027 Peak memory: BINS x 8 bits internal, single write port; wr_en SHALL be 0 whenever no write is issued that cycle.
REQ-028 clear asserted outside IDLE SHALL be held off until IDLE is reached; it is not latched.

Reset
REQ-029 Reset SHALL force wr_en=0, wr_addr=0, wr_data=0, frame_done=0, overrun=0, flush the pipeline (in-flight samples discarded, not written).
REQ-030 The cycle after reset deasserts the block SHALL be in CLEAR, so busy=1 and peak memory is zeroed before any frame.
REQ-031 Reset mid-COLLECT or mid-CLEAR SHALL abandon the operation and restart CLEAR from address 0.

Verification
REQ-032 Reset released -> BINS cycles of wr_en=1, wr_data=0, wr_addr 0..255, then busy=0.
REQ-033 Frame of 256 bins, bin 5 re=-128 im=-128, others 0, DECAY=2 -> wr_addr 5 data 255, all others 0; frame_done 3-4 cycles after last dv.
REQ-034 Next frame all zeros -> bin 5 writes 253, then 251 on the following frame; others stay 0.
REQ-035 Bin 7 re=16 im=0 (p=256) -> data 2; re=127 im=0 (p=16129) -> data 126.
REQ-036 Index 0 reappears after index 100 mid-frame -> overrun=1 and stays 1; frame restarts; frame_done only after index 255.
REQ-037 dv with xk_index 300 in COLLECT -> no write; clear=1 during COLLECT -> no CLEAR until after frame_done.

Source files
------------

// File: rtl/fft_mag_writer.sv
// Converts streaming FFT bins into decaying peak-hold bar heights and writes them
// to a display RAM, one bin per cycle through a fixed 3-stage pipeline.
module fft_mag_writer #(
  parameter int unsigned BINS  = 256,
  parameter int unsigned DECAY = 2
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              dv,
  input  logic [8:0]        xk_index,
  input  logic signed [7:0] xk_re,
  input  logic signed [7:0] xk_im,
  input  logic              clear,
  output logic              wr_en,
  output logic [8:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned AW  = 9;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned DW  = 8;
  localparam int unsigned DW1 = DW + 1;
  localparam int unsigned PW  = 16;
  localparam int unsigned MW  = $clog2(BINS);

  localparam logic [AW1-1:0] BINS_W   = AW1'(BINS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(BINS - 1);
  localparam logic [DW1-1:0] DECAY_W  = (DECAY > 255) ? DW1'(256) : DW1'(DECAY);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   clr_addr, clr_addr_next;

  logic            s1_valid;
  logic [AW-1:0]   s1_idx;
  logic signed [DW-1:0] s1_re, s1_im;
  logic            s2_valid;
  logic [AW-1:0]   s2_idx;
  logic [PW-1:0]   s2_p;
  logic [DW-1:0]   s2_old;

  logic [DW-1:0]   peak_mem [BINS];

  logic            in_range_c, accept_c;
  logic signed [PW-1:0] re_sq_c, im_sq_c;
  logic [PW-1:0]   p_c, p_shr_c;
  logic [DW-1:0]   m_c, dec_c, bar_c, old_rd_c;

  logic            wr_en_d, frame_done_d, busy_d, overrun_d;
  logic [AW-1:0]   wr_addr_d;
  logic [DW-1:0]   wr_data_d;

  // Sample acceptance: frame start in IDLE, any in-range bin while collecting
  always_comb begin
    in_range_c = ({1'b0, xk_index} < BINS_W);
    accept_c   = dv && in_range_c &&
                 (((state == ST_IDLE) && !clear && (xk_index == '0)) ||
                  (state == ST_COLLECT));
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      ST_CLEAR: begin
        if (clr_addr == LAST_IDX) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end else if (accept_c) begin
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept_c && (xk_index == LAST_IDX)) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!s1_valid && !s2_valid) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // Magnitude, decay and peak-hold datapath
  always_comb begin
    re_sq_c  = PW'(s1_re) * PW'(s1_re);
    im_sq_c  = PW'(s1_im) * PW'(s1_im);
    p_c      = $unsigned(re_sq_c) + $unsigned(im_sq_c);
    p_shr_c  = s2_p >> 7;
    m_c      = (p_shr_c > PW'(255)) ? DW'(255) : DW'(p_shr_c);
    dec_c    = ({1'b0, s2_old} > DECAY_W) ? DW'({1'b0, s2_old} - DECAY_W) : '0;
    bar_c    = (m_c > dec_c) ? m_c : dec_c;
    // Same bin one cycle ahead has not reached the memory yet
    old_rd_c = (s2_valid && (s2_idx == s1_idx)) ? bar_c : peak_mem[MW'(s1_idx)];
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_re    <= '0;
      s1_im    <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_p     <= '0;
      s2_old   <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_idx <= xk_index;
        s1_re  <= xk_re;
        s1_im  <= xk_im;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_p   <= p_c;
        s2_old <= old_rd_c;
      end
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (state == ST_CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_addr;
      wr_data_d = '0;
    end else if (s2_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = s2_idx;
      wr_data_d = bar_c;
    end
    frame_done_d = (state_next == ST_DONE);
    busy_d       = (state_next != ST_IDLE);
    overrun_d    = overrun || ((state == ST_COLLECT) && accept_c && (xk_index == '0));
  end

  // Peak memory shares the display write so both always hold the same bars
  always_ff @(posedge cclk) begin
    if (!reset && wr_en_d) peak_mem[MW'(wr_addr_d)] <= wr_data_d;
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fft_mag_writer.sv
// Directed bench for fft_mag_writer: a peak-hold model feeds an expected-write
// queue that is drained as the display writes appear.
module tb_fft_mag_writer;

  localparam int BINS  = 256;
  localparam int DECAY = 2;

  logic              cclk = 1'b0;
  logic              reset, dv, clear;
  logic [8:0]        xk_index;
  logic signed [7:0] xk_re, xk_im;
  logic              wr_en, frame_done, busy, overrun;
  logic [8:0]        wr_addr;
  logic [7:0]        wr_data;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q [$];
  int          mdl  [BINS];
  int          re_v [BINS];
  int          im_v [BINS];

  fft_mag_writer #(.BINS(BINS), .DECAY(DECAY)) dut (
    .cclk       (cclk),
    .reset      (reset),
    .dv         (dv),
    .xk_index   (xk_index),
    .xk_re      (xk_re),
    .xk_im      (xk_im),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Advance one clock, then drain any display write against the queue
  task automatic cycle();
    logic [16:0] e;
    @(posedge cclk);
    #1;
    if (wr_en === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_write: got addr %0d data %0d expected no write", wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", 32'({wr_addr, wr_data}), 32'(e));
      end
    end
  endtask

  task automatic expect_sample(input int idx, input int re, input int im);
    int p, m, od;
    p  = re * re + im * im;
    m  = p >> 7;
    if (m > 255) m = 255;
    od = (mdl[idx] > DECAY) ? mdl[idx] - DECAY : 0;
    mdl[idx] = (m > od) ? m : od;
    exp_q.push_back({9'(idx), 8'(mdl[idx])});
  endtask

  task automatic send(input int idx, input int re, input int im, input bit acc);
    dv       = 1'b1;
    xk_index = 9'(idx);
    xk_re    = 8'(re);
    xk_im    = 8'(im);
    if (acc) expect_sample(idx, re, im);
    cycle();
    dv = 1'b0;
  endtask

  task automatic push_clear();
    for (int a = 0; a < BINS; a++) begin
      exp_q.push_back({9'(a), 8'd0});
      mdl[a] = 0;
    end
  endtask

  task automatic set_zero();
    for (int a = 0; a < BINS; a++) begin
      re_v[a] = 0;
      im_v[a] = 0;
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < limit) begin
      cycle();
      n++;
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (frame_done !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
    end
    checks++;
    assert (frame_done === 1'b1 && lat >= 3 && lat <= 4) else begin
      errors++;
      $error("FAIL %s_done_latency: got %0d cycles (frame_done %b) required 3..4", tag, lat, frame_done);
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    cycle();
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < BINS; i++) begin
      send(i, re_v[i], im_v[i], 1'b1);
      if (i == 128) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
    end
    wait_done(tag);
  endtask

  initial begin
    reset = 1'b1; dv = 1'b0; clear = 1'b0;
    xk_index = '0; xk_re = '0; xk_im = '0;
    repeat (3) cycle();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    reset = 1'b0;
    push_clear();
    cycle();
    chk("busy_after_reset", 32'(busy), 32'd1);
    wait_idle(400, "init_clear");

    // Full-scale bin 5 and a small bin 7
    set_zero();
    re_v[5] = -128; im_v[5] = -128; re_v[7] = 16;
    repeat (2) cycle();
    run_frame("frame_a");

    // Decay of bin 5, new peak on bin 7
    set_zero();
    re_v[7] = 127;
    run_frame("frame_b");

    // Back-to-back and gap-of-one repeats, dv gap, dropped indices, clear held off
    set_zero();
    re_v[10] = 127; re_v[20] = 127;
    for (int i = 0; i < BINS; i++) begin
      send(i, re_v[i], im_v[i], 1'b1);
      if (i == 10) send(10, 0, 0, 1'b1);
      if (i == 20) begin
        send(21, 0, 0, 1'b1);
        send(20, 0, 0, 1'b1);
      end
      if (i == 30) begin
        repeat (5) cycle();
        send(300, 100, 100, 1'b0);
        send(511, 0, 0, 1'b0);
      end
      if (i == 40) clear = 1'b1;
    end
    wait_done("frame_c");
    chk("frame_c_overrun", 32'(overrun), 32'd0);
    push_clear();
    repeat (3) cycle();
    clear = 1'b0;
    wait_idle(400, "clear_after_frame");

    // Restart at index 0 after index 100
    chk("overrun_before", 32'(overrun), 32'd0);
    for (int i = 0; i <= 100; i++) send(i, (i == 5) ? -128 : 0, (i == 5) ? -128 : 0, 1'b1);
    send(0, 0, 0, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_no_done", 32'(frame_done), 32'd0);
    for (int i = 1; i < BINS; i++) send(i, 0, 0, 1'b1);
    wait_done("frame_d");
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame discards in-flight samples, then reset mid-clear restarts it
    for (int i = 0; i <= 50; i++) send(i, 0, 0, 1'b1);
    reset = 1'b1;
    cycle();
    chk("rst_mid_frame_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_frame_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    cycle();
    reset = 1'b0;
    push_clear();
    repeat (100) cycle();
    reset = 1'b1;
    cycle();
    chk("rst_mid_clear_wr_en", 32'(wr_en), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    push_clear();
    wait_idle(400, "clear_after_reset");

    // Peak memory must be zero after the restarted clear
    set_zero();
    run_frame("frame_e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
